// File: rtl/grade_judge_if.sv
// rtl/grade_judge_if.sv - Bundled song/key inputs and scoring outputs of the grade judge
//
// Purpose : groups the sequencer/keyboard-side controls and the display-side
//           results of grade_judge into one bus. The song side (master) drives
//           start/song_end/exp_valid/expected/played; the judge (slave) returns
//           busy, window state, per-window pulses, counters and the final grade.
// Ports   : start, song_end, exp_valid   - 1-cycle control pulses
//           expected, played              - NOTE_W key vectors
//           busy, win_open                - judge status
//           hit_pulse, miss_pulse         - one pulse per scored window
//           hit_cnt, miss_cnt             - CNT_W saturating counters
//           grade, grade_valid            - 7-seg grade code and its qualifier

interface grade_judge_if #(
    parameter int NOTE_W = 10,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              song_end;
    logic              exp_valid;
    logic [NOTE_W-1:0] expected;
    logic [NOTE_W-1:0] played;
    logic              busy;
    logic              win_open;
    logic              hit_pulse;
    logic              miss_pulse;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic [5:0]        grade;
    logic              grade_valid;

    modport master (
        output start, song_end, exp_valid, expected, played,
        input  busy, win_open, hit_pulse, miss_pulse, hit_cnt, miss_cnt, grade, grade_valid
    );

    modport slave (
        input  start, song_end, exp_valid, expected, played,
        output busy, win_open, hit_pulse, miss_pulse, hit_cnt, miss_cnt, grade, grade_valid
    );
endinterface

// File: rtl/grade_judge.sv
// rtl/grade_judge.sv - Per-note hit/miss judgement and end-of-song grading
//
// Purpose : every expected note opens a WIN_CYC-cycle judgement window that is
//           scored hit or miss against the live key vector. Rest notes (all-zero
//           expected) score hit only if no key was pressed during the window.
//           At song end the hit ratio is graded S/A/B/C/D against the
//           programmable percentage thresholds without any division.
// Ports   : clk  - system clock
//           rst  - asynchronous reset, active-low
//           bus  - grade_judge_if slave: controls/keys in, status/results out

module grade_judge #(
    parameter int NOTE_W  = 10,
    parameter int WIN_CYC = 100000,
    parameter int CNT_W   = 8,
    parameter int S_PCT   = 95,
    parameter int A_PCT   = 85,
    parameter int B_PCT   = 70,
    parameter int C_PCT   = 50
) (
    input  logic clk,
    input  logic rst,
    grade_judge_if.slave bus
);

    localparam int TMR_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int TOT_W  = CNT_W + 1;
    localparam int PROD_W = CNT_W + 8;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_JUDGE = 2'd1;
    localparam logic [1:0] ST_GRADE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0] GR_S = 6'b010010;
    localparam logic [5:0] GR_A = 6'b000000;
    localparam logic [5:0] GR_B = 6'b000001;
    localparam logic [5:0] GR_C = 6'b000010;
    localparam logic [5:0] GR_D = 6'b000011;

    logic [1:0]        state_q, state_d;
    logic              win_open_q, win_open_d;
    logic [NOTE_W-1:0] exp_q, exp_d;
    logic              seen_q, seen_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [5:0]        grade_q, grade_d;
    logic              grade_valid_q, grade_valid_d;

    // ------------------------------------------------------------------
    // Window scoring terms, meaningful only while win_open_q is set
    // ------------------------------------------------------------------
    logic is_rest;
    logic key_match;
    logic dirty;
    logic win_expire;
    logic force_close;
    logic score_now;
    logic score_hit;

    assign is_rest    = (exp_q == '0);
    // A rest never "matches": an idle keyboard equals the all-zero vector.
    assign key_match  = !is_rest && (bus.played == exp_q);
    // Includes the current sample so a rest closed this cycle sees it.
    assign dirty      = seen_q || (bus.played != '0);
    assign win_expire = (timer_q == TMR_LAST);
    // A new note or the song end closes the running window as if expired.
    assign force_close = bus.exp_valid || bus.song_end;
    assign score_now  = key_match || win_expire || force_close;
    // Match wins over a simultaneous expiry or forced close.
    assign score_hit  = is_rest ? !dirty : key_match;

    // ------------------------------------------------------------------
    // Grade evaluation: hit*100 >= total*PCT, checked from S down to C
    // ------------------------------------------------------------------
    logic [TOT_W-1:0]  total;
    logic [PROD_W-1:0] hit_x100;
    logic [PROD_W-1:0] need_s;
    logic [PROD_W-1:0] need_a;
    logic [PROD_W-1:0] need_b;
    logic [PROD_W-1:0] need_c;
    logic [5:0]        grade_calc;

    assign total    = TOT_W'(hit_cnt_q) + TOT_W'(miss_cnt_q);
    assign hit_x100 = PROD_W'(hit_cnt_q) * PROD_W'(100);
    assign need_s   = PROD_W'(total) * PROD_W'(S_PCT);
    assign need_a   = PROD_W'(total) * PROD_W'(A_PCT);
    assign need_b   = PROD_W'(total) * PROD_W'(B_PCT);
    assign need_c   = PROD_W'(total) * PROD_W'(C_PCT);

    always_comb begin
        grade_calc = GR_D;
        if (total == '0) begin
            grade_calc = GR_D;
        end else if (hit_x100 >= need_s) begin
            grade_calc = GR_S;
        end else if (hit_x100 >= need_a) begin
            grade_calc = GR_A;
        end else if (hit_x100 >= need_b) begin
            grade_calc = GR_B;
        end else if (hit_x100 >= need_c) begin
            grade_calc = GR_C;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        win_open_d    = win_open_q;
        exp_d         = exp_q;
        seen_d        = seen_q;
        timer_d       = timer_q;
        hit_pulse_d   = 1'b0;
        miss_pulse_d  = 1'b0;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        grade_d       = grade_q;
        grade_valid_d = grade_valid_q;

        if (bus.start) begin
            // Start overrides everything, including a song_end in the same
            // cycle; an open window is dropped without a score.
            state_d       = ST_JUDGE;
            win_open_d    = 1'b0;
            seen_d        = 1'b0;
            timer_d       = '0;
            hit_cnt_d     = '0;
            miss_cnt_d    = '0;
            grade_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end

                ST_JUDGE: begin
                    if (win_open_q) begin
                        if (score_now) begin
                            win_open_d = 1'b0;
                            if (score_hit) begin
                                hit_pulse_d = 1'b1;
                                if (hit_cnt_q != CNT_MAX) begin
                                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                                end
                            end else begin
                                miss_pulse_d = 1'b1;
                                if (miss_cnt_q != CNT_MAX) begin
                                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                                end
                            end
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                            seen_d  = dirty;
                        end
                    end

                    if (bus.song_end) begin
                        state_d = ST_GRADE;
                    end else if (bus.exp_valid) begin
                        // Opens on the same edge that scored the old window.
                        win_open_d = 1'b1;
                        exp_d      = bus.expected;
                        timer_d    = '0;
                        seen_d     = 1'b0;
                    end
                end

                ST_GRADE: begin
                    state_d       = ST_DONE;
                    grade_d       = grade_calc;
                    grade_valid_d = 1'b1;
                end

                ST_DONE: begin
                    state_d = ST_DONE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            win_open_q    <= 1'b0;
            exp_q         <= '0;
            seen_q        <= 1'b0;
            timer_q       <= '0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            grade_q       <= 6'b000000;
            grade_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_open_q    <= win_open_d;
            exp_q         <= exp_d;
            seen_q        <= seen_d;
            timer_q       <= timer_d;
            hit_pulse_q   <= hit_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            grade_q       <= grade_d;
            grade_valid_q <= grade_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy        = (state_q == ST_JUDGE);
    assign bus.win_open    = win_open_q;
    assign bus.hit_pulse   = hit_pulse_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.hit_cnt     = hit_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.grade       = grade_q;
    assign bus.grade_valid = grade_valid_q;

endmodule

// File: tb/tb_grade_judge.sv
// tb/tb_grade_judge.sv - Self-checking bench for grade_judge (two counter widths)

module tb_grade_judge;

    localparam int NW   = 10;
    localparam int WIN  = 8;
    localparam int CW_A = 8;
    localparam int CW_B = 4;
    localparam int MAXC = 1024;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    localparam logic [5:0] G_S = 6'b010010;
    localparam logic [5:0] G_A = 6'b000000;
    localparam logic [5:0] G_B = 6'b000001;
    localparam logic [5:0] G_C = 6'b000010;
    localparam logic [5:0] G_D = 6'b000011;

    logic          clk;
    logic          rst;
    logic          start;
    logic          song_end;
    logic          exp_valid;
    logic [NW-1:0] expected;
    logic [NW-1:0] played;

    int n_tests = 0;
    int n_fail  = 0;

    grade_judge_if #(.NOTE_W(NW), .CNT_W(CW_A)) if_a ();
    grade_judge_if #(.NOTE_W(NW), .CNT_W(CW_B)) if_b ();

    assign if_a.start     = start;
    assign if_a.song_end  = song_end;
    assign if_a.exp_valid = exp_valid;
    assign if_a.expected  = expected;
    assign if_a.played    = played;
    assign if_b.start     = start;
    assign if_b.song_end  = song_end;
    assign if_b.exp_valid = exp_valid;
    assign if_b.expected  = expected;
    assign if_b.played    = played;

    grade_judge #(.NOTE_W(NW), .WIN_CYC(WIN), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    grade_judge #(.NOTE_W(NW), .WIN_CYC(WIN), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Song description: one entry per note, played samples per window index.
    int            n_notes;
    logic [NW-1:0] nt_exp [64];
    int            nt_gap [64];
    logic [NW-1:0] nt_pat [64][16];

    // Per-cycle drive schedule and expected observations.
    bit            sc_ev  [MAXC];
    logic [NW-1:0] sc_exp [MAXC];
    logic [NW-1:0] sc_pl  [MAXC];
    bit            sc_se  [MAXC];
    bit            x_hit  [MAXC];
    bit            x_miss [MAXC];
    bit            x_win  [MAXC];
    bit            x_busy [MAXC];
    int            x_h    [MAXC];
    int            x_m    [MAXC];
    int            sc_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [5:0] grade_of(input int h, input int m);
        int t;
        t = h + m;
        if (t == 0)             return G_D;
        if (h * 100 >= t * 95)  return G_S;
        if (h * 100 >= t * 85)  return G_A;
        if (h * 100 >= t * 70)  return G_B;
        if (h * 100 >= t * 50)  return G_C;
        return G_D;
    endfunction

    // Random note whose played pattern is shaped to score the wanted result.
    task automatic gen_note(input int i, input bit want_hit);
        bit            rest;
        logic [NW-1:0] e;
        logic [NW-1:0] v;
        int            g;
        int            last;
        rest = ($urandom_range(0, 3) == 0);
        e    = rest ? '0 : NW'($urandom_range(1, (1 << NW) - 1));
        g    = $urandom_range(0, 11);
        last = (g < WIN - 1) ? g : WIN - 1;
        nt_exp[i] = e;
        nt_gap[i] = g;
        for (int j = 0; j < 16; j++) begin
            v = NW'($urandom);
            if (v == e) v = v ^ NW'(1);
            nt_pat[i][j] = v;
        end
        if (rest) begin
            for (int j = 0; j <= last; j++) nt_pat[i][j] = '0;
            if (!want_hit) nt_pat[i][$urandom_range(0, last)] = NW'($urandom_range(1, (1 << NW) - 1));
        end else if (want_hit) begin
            nt_pat[i][$urandom_range(0, last)] = e;
        end
    endtask

    // Cycle 0 is the first JUDGE cycle after start. Note i's exp_valid cycle
    // is followed by nt_gap+1 cycles of its samples; the last of those is the
    // next note's exp_valid (or the song_end) cycle.
    task automatic build_schedule();
        int e;
        int last;
        int close_i;
        bit hit;
        int h;
        int m;
        for (int k = 0; k < MAXC; k++) begin
            sc_ev[k]  = 1'b0;
            sc_exp[k] = NW'($urandom);
            sc_pl[k]  = NW'($urandom);
            sc_se[k]  = 1'b0;
            x_hit[k]  = 1'b0;
            x_miss[k] = 1'b0;
            x_win[k]  = 1'b0;
            x_busy[k] = 1'b0;
        end
        e = 0;
        for (int i = 0; i < n_notes; i++) begin
            sc_ev[e]  = 1'b1;
            sc_exp[e] = nt_exp[i];
            last      = (nt_gap[i] < WIN - 1) ? nt_gap[i] : WIN - 1;
            close_i   = last;
            if (nt_exp[i] != '0) begin
                hit = 1'b0;
                for (int j = 0; j <= last; j++) begin
                    if (!hit && nt_pat[i][j] == nt_exp[i]) begin
                        hit     = 1'b1;
                        close_i = j;
                    end
                end
            end else begin
                hit = 1'b1;
                for (int j = 0; j <= last; j++) if (nt_pat[i][j] != '0) hit = 1'b0;
            end
            for (int j = 0; j <= nt_gap[i]; j++) sc_pl[e + 1 + j] = nt_pat[i][j];
            for (int j = 0; j <= close_i; j++) x_win[e + 1 + j] = 1'b1;
            x_hit[e + 2 + close_i]  = hit;
            x_miss[e + 2 + close_i] = !hit;
            e = e + 1 + nt_gap[i];
        end
        sc_se[e] = 1'b1;
        for (int k = 0; k <= e; k++) x_busy[k] = 1'b1;
        sc_len = e + 3;
        h = 0;
        m = 0;
        for (int k = 0; k < sc_len; k++) begin
            h += int'(x_hit[k]);
            m += int'(x_miss[k]);
            x_h[k] = h;
            x_m[k] = m;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a_busy"}, 32'(if_a.busy), 32'd0);
        chk({tag, " a_win"}, 32'(if_a.win_open), 32'd0);
        chk({tag, " a_hitp"}, 32'(if_a.hit_pulse), 32'd0);
        chk({tag, " a_missp"}, 32'(if_a.miss_pulse), 32'd0);
        chk({tag, " a_hcnt"}, 32'(if_a.hit_cnt), 32'd0);
        chk({tag, " a_mcnt"}, 32'(if_a.miss_cnt), 32'd0);
        chk({tag, " a_grade"}, 32'(if_a.grade), 32'd0);
        chk({tag, " a_gvalid"}, 32'(if_a.grade_valid), 32'd0);
        chk({tag, " b_win"}, 32'(if_b.win_open), 32'd0);
        chk({tag, " b_busy"}, 32'(if_b.busy), 32'd0);
        chk({tag, " b_gvalid"}, 32'(if_b.grade_valid), 32'd0);
    endtask

    task automatic check_cycle(input string tag, input int k, input logic [5:0] ga, input logic [5:0] gb);
        string t;
        bit    fin;
        t   = $sformatf("%s c%0d", tag, k);
        fin = (k == sc_len - 1);
        chk({t, " a_win"}, 32'(if_a.win_open), 32'(x_win[k]));
        chk({t, " a_hitp"}, 32'(if_a.hit_pulse), 32'(x_hit[k]));
        chk({t, " a_missp"}, 32'(if_a.miss_pulse), 32'(x_miss[k]));
        chk({t, " a_busy"}, 32'(if_a.busy), 32'(x_busy[k]));
        chk({t, " a_hcnt"}, 32'(if_a.hit_cnt), 32'(sat(x_h[k], MAX_A)));
        chk({t, " a_mcnt"}, 32'(if_a.miss_cnt), 32'(sat(x_m[k], MAX_A)));
        chk({t, " a_gvalid"}, 32'(if_a.grade_valid), 32'(fin));
        chk({t, " b_win"}, 32'(if_b.win_open), 32'(x_win[k]));
        chk({t, " b_hitp"}, 32'(if_b.hit_pulse), 32'(x_hit[k]));
        chk({t, " b_missp"}, 32'(if_b.miss_pulse), 32'(x_miss[k]));
        chk({t, " b_hcnt"}, 32'(if_b.hit_cnt), 32'(sat(x_h[k], MAX_B)));
        chk({t, " b_mcnt"}, 32'(if_b.miss_cnt), 32'(sat(x_m[k], MAX_B)));
        chk({t, " b_gvalid"}, 32'(if_b.grade_valid), 32'(fin));
        if (fin) begin
            chk({t, " a_grade"}, 32'(if_a.grade), 32'(ga));
            chk({t, " b_grade"}, 32'(if_b.grade), 32'(gb));
        end
    endtask

    task automatic run_song(input string tag);
        logic [5:0] ga;
        logic [5:0] gb;
        int         hf;
        int         mf;
        build_schedule();
        hf = x_h[sc_len - 1];
        mf = x_m[sc_len - 1];
        ga = grade_of(sat(hf, MAX_A), sat(mf, MAX_A));
        gb = grade_of(sat(hf, MAX_B), sat(mf, MAX_B));
        @(posedge clk); #1;
        start = 1'b1; song_end = 1'b0; exp_valid = 1'b0; expected = '0; played = '0;
        for (int k = 0; k < sc_len; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check_cycle(tag, k, ga, gb);
            exp_valid = sc_ev[k];
            expected  = sc_exp[k];
            played    = sc_pl[k];
            song_end  = sc_se[k];
        end
        // DONE holds its results and ignores notes.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s done%0d a_win", tag, k), 32'(if_a.win_open), 32'd0);
            chk($sformatf("%s done%0d a_hitp", tag, k), 32'(if_a.hit_pulse), 32'd0);
            chk($sformatf("%s done%0d a_busy", tag, k), 32'(if_a.busy), 32'd0);
            chk($sformatf("%s done%0d a_grade", tag, k), 32'(if_a.grade), 32'(ga));
            chk($sformatf("%s done%0d a_gvalid", tag, k), 32'(if_a.grade_valid), 32'd1);
            chk($sformatf("%s done%0d a_hcnt", tag, k), 32'(if_a.hit_cnt), 32'(sat(hf, MAX_A)));
            chk($sformatf("%s done%0d b_grade", tag, k), 32'(if_b.grade), 32'(gb));
            exp_valid = (k == 0);
            expected  = 10'h004;
            played    = 10'h004;
            song_end  = 1'b0;
        end
        exp_valid = 1'b0;
        played    = '0;
    endtask

    task automatic graded_song(input string tag, input int hits, input int notes);
        int idx [20];
        int r;
        int tmp;
        for (int i = 0; i < notes; i++) idx[i] = i;
        for (int i = notes - 1; i > 0; i--) begin
            r = $urandom_range(0, i);
            tmp = idx[i]; idx[i] = idx[r]; idx[r] = tmp;
        end
        n_notes = notes;
        for (int i = 0; i < notes; i++) gen_note(i, idx[i] < hits);
        run_song(tag);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; song_end = 1'b0; exp_valid = 1'b0;
        expected = '0; played = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Matching key at window index 3.
        n_notes = 1; nt_exp[0] = 10'h004; nt_gap[0] = 10;
        for (int j = 0; j < 16; j++) nt_pat[0][j] = '0;
        nt_pat[0][3] = 10'h004;
        run_song("hit");

        // Never matching: miss pulse 8 cycles after the window opens.
        n_notes = 1; nt_exp[0] = 10'h010; nt_gap[0] = 11;
        for (int j = 0; j < 16; j++) nt_pat[0][j] = 10'h020;
        run_song("miss");

        // Dirty rest, then clean rest.
        n_notes = 2;
        nt_exp[0] = '0; nt_gap[0] = 9; nt_exp[1] = '0; nt_gap[1] = 9;
        for (int j = 0; j < 16; j++) begin
            nt_pat[0][j] = '0;
            nt_pat[1][j] = '0;
        end
        nt_pat[0][4] = 10'h001;
        nt_pat[1][9] = 10'h3ff;
        run_song("rest");

        // Start during an open window (with song_end): no score, counters clear.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; exp_valid = 1'b1; expected = 10'h004; played = '0;
        @(posedge clk); #1;
        exp_valid = 1'b0; played = 10'h004;
        @(posedge clk); #1;
        chk("ovr a_hitp", 32'(if_a.hit_pulse), 32'd1);
        chk("ovr a_hcnt", 32'(if_a.hit_cnt), 32'd1);
        played = '0; exp_valid = 1'b1; expected = 10'h010;
        @(posedge clk); #1;
        chk("ovr a_win_open", 32'(if_a.win_open), 32'd1);
        exp_valid = 1'b0; start = 1'b1; song_end = 1'b1; played = 10'h010;
        @(posedge clk); #1;
        start = 1'b0; song_end = 1'b0; played = '0;
        chk("ovr a_hitp2", 32'(if_a.hit_pulse), 32'd0);
        chk("ovr a_missp2", 32'(if_a.miss_pulse), 32'd0);
        chk("ovr a_win", 32'(if_a.win_open), 32'd0);
        chk("ovr a_hcnt2", 32'(if_a.hit_cnt), 32'd0);
        chk("ovr a_busy", 32'(if_a.busy), 32'd1);
        chk("ovr b_busy", 32'(if_b.busy), 32'd1);

        // Grade thresholds, saturation at 20 hits, and an empty song.
        graded_song("g19", 19, 20);
        graded_song("g17", 17, 20);
        graded_song("g16", 16, 20);
        graded_song("g14", 14, 20);
        graded_song("g10", 10, 20);
        graded_song("g9", 9, 20);
        graded_song("g20", 20, 20);
        n_notes = 0;
        run_song("empty");

        for (int s = 0; s < 4; s++) begin
            n_notes = $urandom_range(1, 20);
            for (int i = 0; i < n_notes; i++) gen_note(i, 1'($urandom_range(0, 1)));
            run_song($sformatf("rnd%0d", s));
        end

        // Reset while a window is open.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; exp_valid = 1'b1; expected = 10'h004; played = '0;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid a_win_before", 32'(if_a.win_open), 32'd1);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rstmid");
        rst = 1'b1;

        graded_song("after_rst", 3, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
